// File: rtl/mdr_arbiter.sv
// rtl/mdr_arbiter.sv - round-robin arbiter sharing one mdr unit between two requesters
// Optional wait-state timeout: define MDR_ARB_TIMEOUT_EN.
module mdr_arbiter #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_req,
    input  logic [1:0][1:0]    i_op,
    input  logic [1:0][DW-1:0] i_data_x,
    input  logic [1:0][DW-1:0] i_data_y,
    input  logic [1:0]         i_ack,
    output logic [1:0]         o_gnt,
    output logic [1:0]         o_valid,
    output logic [DW-1:0]      o_result,
    output logic [DW-1:0]      o_reminder,
    output logic               o_err,
    output logic               o_timeout,
    output logic               o_busy,
    output logic               o_mdr_start,
    output logic               o_mdr_load,
    output logic [DW-1:0]      o_mdr_data,
    output logic [1:0]         o_mdr_op,
    input  logic               i_mdr_load_x,
    input  logic               i_mdr_load_y,
    input  logic               i_mdr_ready,
    input  logic               i_mdr_error,
    input  logic [DW-1:0]      i_mdr_result,
    input  logic [DW-1:0]      i_mdr_reminder
);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, BUSY, RESP
    } state_t;

    state_t          state, next_state;
    logic            win, owner, ptr;
    logic [1:0]      op_r;
    logic [DW-1:0]   x_r, y_r;
    logic            timeout_hit;

    logic [1:0]      gnt_d, valid_d, op_d;
    logic [DW-1:0]   result_d, rem_d, data_d;
    logic            err_d, busy_d, start_d, load_d;

    // ptr holds the last winner, so on a tie the other requester goes first
    always_comb begin
        if (i_req == 2'b11) win = ~ptr;
        else                win = i_req[1];
    end

`ifdef MDR_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
    logic          tmo_d;
    logic          waiting;

    assign waiting     = (state == WAIT_X) || (state == WAIT_Y) || (state == BUSY);
    assign timeout_hit = waiting && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      wait_cnt <= '0;
        else if (next_state != state) wait_cnt <= '0;
        else if (waiting)             wait_cnt <= wait_cnt + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|i_req) next_state = START;
            START:   next_state = WAIT_X;
            WAIT_X:  if (i_mdr_load_x) next_state = LOAD_X;
                     else if (timeout_hit) next_state = RESP;
            LOAD_X:  next_state = WAIT_Y;
            WAIT_Y:  if (i_mdr_load_y) next_state = LOAD_Y;
                     else if (timeout_hit) next_state = RESP;
            LOAD_Y:  next_state = BUSY;
            BUSY:    if (i_mdr_error || i_mdr_ready || timeout_hit) next_state = RESP;
            RESP:    if (i_ack[owner]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 1'b0;
            ptr   <= 1'b1;
            op_r  <= '0;
            x_r   <= '0;
            y_r   <= '0;
        end else if (state == IDLE && |i_req) begin
            owner <= win;
            ptr   <= win;
            op_r  <= i_op[win];
            x_r   <= i_data_x[win];
            y_r   <= i_data_y[win];
        end
    end

    // Next values for the registered outputs, decoded from the state being entered
    always_comb begin
        gnt_d    = '0;
        valid_d  = '0;
        start_d  = 1'b0;
        load_d   = 1'b0;
        data_d   = '0;
        busy_d   = (next_state != IDLE);
        op_d     = '0;
        result_d = o_result;
        rem_d    = o_reminder;
        err_d    = o_err;
`ifdef MDR_ARB_TIMEOUT_EN
        tmo_d    = o_timeout;
`endif
        if (next_state != IDLE) op_d = (state == IDLE) ? i_op[win] : op_r;
        case (next_state)
            START:   begin gnt_d[win] = 1'b1; start_d = 1'b1; end
            LOAD_X:  begin load_d = 1'b1; data_d = x_r; end
            LOAD_Y:  begin load_d = 1'b1; data_d = y_r; end
            RESP:    valid_d[owner] = 1'b1;
            default: ;
        endcase
        // Error wins over ready; anything else reaching RESP is a timeout
        if (next_state == RESP && state != RESP) begin
            if (state == BUSY && i_mdr_ready && !i_mdr_error) begin
                result_d = i_mdr_result;
                rem_d    = i_mdr_reminder;
                err_d    = 1'b0;
            end else begin
                result_d = '0;
                rem_d    = '0;
                err_d    = 1'b1;
            end
`ifdef MDR_ARB_TIMEOUT_EN
            tmo_d = !(state == BUSY && (i_mdr_ready || i_mdr_error));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_gnt       <= '0;
            o_valid     <= '0;
            o_result    <= '0;
            o_reminder  <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_mdr_start <= 1'b0;
            o_mdr_load  <= 1'b0;
            o_mdr_data  <= '0;
            o_mdr_op    <= '0;
        end else begin
            o_gnt       <= gnt_d;
            o_valid     <= valid_d;
            o_result    <= result_d;
            o_reminder  <= rem_d;
            o_err       <= err_d;
            o_busy      <= busy_d;
            o_mdr_start <= start_d;
            o_mdr_load  <= load_d;
            o_mdr_data  <= data_d;
            o_mdr_op    <= op_d;
        end
    end

`ifdef MDR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_timeout <= 1'b0;
        else     o_timeout <= tmo_d;
    end
`endif

endmodule

// File: tb/tb_mdr_arbiter.sv
// tb/tb_mdr_arbiter.sv - scoreboard bench for mdr_arbiter with a behavioural mdr model
module tb_mdr_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       i_req;
    logic [1:0][1:0]  i_op;
    logic [1:0][15:0] i_data_x, i_data_y;
    logic [1:0]       i_ack;
    logic [1:0]       o_gnt, o_valid, o_mdr_op;
    logic [15:0]      o_result, o_reminder, o_mdr_data;
    logic             o_err, o_timeout, o_busy, o_mdr_start, o_mdr_load;
    logic             i_mdr_load_x, i_mdr_load_y, i_mdr_ready, i_mdr_error;
    logic [15:0]      i_mdr_result, i_mdr_reminder;

    mdr_arbiter #(.DW(16), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_op(i_op),
        .i_data_x(i_data_x), .i_data_y(i_data_y), .i_ack(i_ack),
        .o_gnt(o_gnt), .o_valid(o_valid), .o_result(o_result),
        .o_reminder(o_reminder), .o_err(o_err), .o_timeout(o_timeout),
        .o_busy(o_busy), .o_mdr_start(o_mdr_start), .o_mdr_load(o_mdr_load),
        .o_mdr_data(o_mdr_data), .o_mdr_op(o_mdr_op),
        .i_mdr_load_x(i_mdr_load_x), .i_mdr_load_y(i_mdr_load_y),
        .i_mdr_ready(i_mdr_ready), .i_mdr_error(i_mdr_error),
        .i_mdr_result(i_mdr_result), .i_mdr_reminder(i_mdr_reminder)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; logic [1:0] op; logic [15:0] x; logic [15:0] y; bit no_y; } ld_t;
    typedef struct { logic [15:0] res; logic [15:0] rem; bit err; bit rdy; bit no_y; int delay; } md_t;
    typedef struct { int owner; logic [15:0] res; logic [15:0] rem; bit err; bit tmo; } rs_t;

    ld_t load_q[$];
    md_t mdr_q[$];
    rs_t resp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  req_cnt[2] = '{0, 0};
    bit  computing = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic plan(input int n, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] mres, input logic [15:0] mrem, input bit merr, input bit mrdy,
                        input bit no_y, input int delay, input bit has_resp,
                        input logic [15:0] eres, input logic [15:0] erem, input bit eerr, input bit etmo);
        load_q.push_back('{owner: n, op: op, x: x, y: y, no_y: no_y});
        mdr_q.push_back('{res: mres, rem: mrem, err: merr, rdy: mrdy, no_y: no_y, delay: delay});
        if (has_resp) resp_q.push_back('{owner: n, res: eres, rem: erem, err: eerr, tmo: etmo});
    endtask

    task automatic issue(input int n, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        i_op[n]     = op;
        i_data_x[n] = x;
        i_data_y[n] = y;
        req_cnt[n]++;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        @(negedge clk);
        while ((resp_q.size() != 0 || load_q.size() != 0 || o_busy) && k < max) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= max) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, o_gnt, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_reminder"}, o_reminder, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_timeout"}, o_timeout, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_start"}, o_mdr_start, 0);
        check({tag, "_load"}, o_mdr_load, 0);
        check({tag, "_data"}, o_mdr_data, 0);
        check({tag, "_op"}, o_mdr_op, 0);
    endtask

    // Requester driver: i_req[n] stays up from issue until its grant is seen
    initial begin
        int served[2];
        served = '{0, 0};
        i_req = 2'b00;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (o_gnt[n]) served[n]++;
                i_req[n] = (req_cnt[n] != served[n]);
            end
        end
    end

    // Responder: ack every response in its first cycle; valid must then drop
    initial begin
        bit acked;
        acked = 1'b0;
        i_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (acked) check("valid_clears_after_ack", o_valid, 2'b00);
            i_ack = o_valid;
            acked = (o_valid != 2'b00);
        end
    end

    // Behavioural mdr: asks for X right after start, Y right after X, then computes
    initial begin
        md_t cur;
        int  cnt;
        cur = '{res: 0, rem: 0, err: 0, rdy: 0, no_y: 0, delay: 0};
        cnt = 0;
        {i_mdr_load_x, i_mdr_load_y, i_mdr_ready, i_mdr_error} = 4'b0;
        i_mdr_result = '0;
        i_mdr_reminder = '0;
        forever begin
            @(negedge clk);
            i_mdr_ready = 1'b0;
            i_mdr_error = 1'b0;
            if (rst) begin
                i_mdr_load_x = 1'b0;
                i_mdr_load_y = 1'b0;
                computing = 1'b0;
            end else if (o_mdr_start) begin
                if (mdr_q.size() != 0) cur = mdr_q.pop_front();
                computing = 1'b0;
                i_mdr_load_x = 1'b1;
            end else if (o_mdr_load && i_mdr_load_x) begin
                i_mdr_load_x = 1'b0;
                i_mdr_load_y = !cur.no_y;
            end else if (o_mdr_load && i_mdr_load_y) begin
                i_mdr_load_y = 1'b0;
                computing = 1'b1;
                cnt = cur.delay;
            end else if (computing) begin
                if (cnt == 0) begin
                    i_mdr_ready = cur.rdy;
                    i_mdr_error = cur.err;
                    i_mdr_result = cur.res;
                    i_mdr_reminder = cur.rem;
                    computing = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: compares grants, operand loads, op/busy and responses against the queues
    initial begin
        int         cyc;
        int         ld_x_cyc;
        logic [1:0] prev_valid;
        logic [1:0] cur_op;
        bit         y_phase;
        bit         in_xact;
        rs_t        r;
        cyc = 0; ld_x_cyc = 0; prev_valid = 2'b00; cur_op = 2'b00; y_phase = 1'b0; in_xact = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_valid = 2'b00;
                y_phase = 1'b0;
                in_xact = 1'b0;
                continue;
            end
            if (prev_valid != 2'b00 && o_valid == 2'b00) in_xact = 1'b0;
            if (o_gnt != 2'b00) begin
                if (load_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_gnt: got %b expected none", o_gnt);
                end else begin
                    check("gnt", o_gnt, 1 << load_q[0].owner);
                    check("mdr_start_with_gnt", o_mdr_start, 1);
                    cur_op = load_q[0].op;
                    y_phase = 1'b0;
                    in_xact = 1'b1;
                end
            end
            check("busy", o_busy, in_xact);
            check("mdr_op", o_mdr_op, in_xact ? cur_op : 2'b00);
            if (o_mdr_load) begin
                if (load_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_load: got data %0h expected no load", o_mdr_data);
                end else if (!y_phase) begin
                    check("load_x_data", o_mdr_data, load_q[0].x);
                    ld_x_cyc = cyc;
                    y_phase = 1'b1;
                    if (load_q[0].no_y) load_q.delete(0);
                end else begin
                    check("load_y_data", o_mdr_data, load_q[0].y);
                    load_q.delete(0);
                    y_phase = 1'b0;
                end
            end else begin
                check("mdr_data_idle", o_mdr_data, 0);
            end
            if (o_valid != 2'b00 && prev_valid == 2'b00) begin
                if (resp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_resp: got valid %b expected none", o_valid);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_valid", o_valid, 1 << r.owner);
                    check("resp_result", o_result, r.res);
                    check("resp_reminder", o_reminder, r.rem);
                    check("resp_err", o_err, r.err);
                    check("resp_timeout", o_timeout, r.tmo);
                    if (r.tmo) check("timeout_latency", cyc - ld_x_cyc, 11);
                end
            end
            prev_valid = o_valid;
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        i_op = '0;
        i_data_x = '0;
        i_data_y = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Tie after reset: requester 0 first, then 1 without a new tie-break
        plan(0, 2'b00, 16'd7, 16'd6, 16'd42, 16'd0, 0, 1, 0, 2, 1, 16'd42, 16'd0, 0, 0);
        plan(1, 2'b01, 16'd17, 16'd5, 16'd3, 16'd2, 0, 1, 0, 3, 1, 16'd3, 16'd2, 0, 0);
        issue(0, 2'b00, 16'd7, 16'd6);
        issue(1, 2'b01, 16'd17, 16'd5);
        wait_idle("tie1", 200);

        // Second tie: 0 again; its divide-by-zero raises error and ready together
        plan(0, 2'b01, 16'd9, 16'd0, 16'hDEAD, 16'hBEEF, 1, 1, 0, 1, 1, 16'd0, 16'd0, 1, 0);
        plan(1, 2'b10, 16'd81, 16'd0, 16'd9, 16'd0, 0, 1, 0, 0, 1, 16'd9, 16'd0, 0, 0);
        issue(0, 2'b01, 16'd9, 16'd0);
        issue(1, 2'b10, 16'd81, 16'd0);
        wait_idle("tie2", 200);

        // mdr never requests Y
`ifdef MDR_ARB_TIMEOUT_EN
        plan(0, 2'b00, 16'd3, 16'd4, 16'd0, 16'd0, 0, 0, 1, 0, 1, 16'd0, 16'd0, 1, 1);
        issue(0, 2'b00, 16'd3, 16'd4);
        wait_idle("timeout", 200);
`else
        plan(0, 2'b00, 16'd3, 16'd4, 16'd0, 16'd0, 0, 0, 1, 0, 0, 16'd0, 16'd0, 0, 0);
        issue(0, 2'b00, 16'd3, 16'd4);
        repeat (6) @(negedge clk);
        k = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (o_busy) k++;
        end
        check("busy_hold_1000", k, 1000);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Single request wins regardless of pointer
        plan(1, 2'b00, 16'd3, 16'd5, 16'd15, 16'd0, 0, 1, 0, 1, 1, 16'd15, 16'd0, 0, 0);
        issue(1, 2'b00, 16'd3, 16'd5);
        wait_idle("single1", 200);

        // Reset while the mdr computes: response is dropped, outputs clear at once
        plan(0, 2'b00, 16'd5, 16'd5, 16'd25, 16'd0, 0, 1, 0, 30, 0, 16'd0, 16'd0, 0, 0);
        issue(0, 2'b00, 16'd5, 16'd5);
        k = 0;
        while (!computing && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reach_busy", computing, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        plan(0, 2'b10, 16'd16, 16'd0, 16'd4, 16'd0, 0, 1, 0, 2, 1, 16'd4, 16'd0, 0, 0);
        issue(0, 2'b10, 16'd16, 16'd0);
        wait_idle("after_reset", 200);

        check("resp_queue_empty", resp_q.size(), 0);
        check("load_queue_empty", load_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdr_arbiter.md
# mdr_arbiter

- Shares one `mdr` multiply/divide/root unit between two requesters.
- Grants requests round-robin and latches the winner's operands.
- Drives the MDR start/load handshake, waits for ready or error, then returns result and remainder to the winning requester under a valid/ack handshake.
- Sits between the system bus adapters and the `mdr` instance.

## Interface
Parameters:
- DW, 16, operand/result width; matches the `data_t` width of `pkg_system_mdr`.
- TIMEOUT, 255, maximum wait cycles in any MDR-wait state. Only used when the timeout feature is compiled in.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  2  request per requester; bit n belongs to requester n.
- i_op  in  2x2  operation per requester (`op_select_t`): 00 mul, 01 div, 10 root.
- i_data_x  in  2xDW  X operand per requester.
- i_data_y  in  2xDW  Y operand per requester.
- i_ack  in  2  requester n has consumed its response.
- o_gnt  out  2  one-cycle pulse: requester n's operands are latched.
- o_valid  out  2  response for requester n is valid; held until acked.
- o_result  out  DW  latched result.
- o_reminder  out  DW  latched remainder.
- o_err  out  1  response is an error (MDR error or timeout).
- o_timeout  out  1  response is a timeout. Tied 0 when the feature is out.
- o_busy  out  1  high in every state except IDLE.
- o_mdr_start  out  1  start pulse to the MDR.
- o_mdr_load  out  1  load pulse to the MDR.
- o_mdr_data  out  DW  operand bus to the MDR.
- o_mdr_op  out  2  operation to the MDR; held for the whole grant.
- i_mdr_load_x  in  1  MDR requests the X operand.
- i_mdr_load_y  in  1  MDR requests the Y operand.
- i_mdr_ready  in  1  MDR result valid.
- i_mdr_error  in  1  MDR rejected the operands.
- i_mdr_result  in  DW  MDR result.
- i_mdr_reminder  in  DW  MDR remainder.

## Operation
States and transitions:
- IDLE: if any i_req is set, choose winner n, latch op/x/y for n, update the last-grant pointer to n -> START.
- START: o_gnt[n]=1, o_mdr_start=1 for one cycle -> WAIT_X.
- WAIT_X: on i_mdr_load_x -> LOAD_X.
- LOAD_X: o_mdr_load=1, o_mdr_data=X for one cycle -> WAIT_Y.
- WAIT_Y: on i_mdr_load_y -> LOAD_Y.
- LOAD_Y: o_mdr_load=1, o_mdr_data=Y for one cycle -> BUSY.
- BUSY:
  - on i_mdr_error: latch o_err=1, o_result=0, o_reminder=0 -> RESP.
  - else on i_mdr_ready: latch i_mdr_result and i_mdr_reminder, o_err=0 -> RESP.
  - Error wins if error and ready are high in the same cycle.
- RESP: o_valid[n]=1 and response fields held. On i_ack[n] -> IDLE. i_ack on the other bit is ignored.

Arbitration and data rules:
- Round-robin. When both requests are set, the requester that was not granted last wins.
- A single request wins regardless of the pointer.
- Reset pointer = 1, so requester 0 wins the first tie.
- Requests are sampled only in IDLE; a request arriving in any other state waits.
- The requester must hold op/x/y stable from raising i_req until o_gnt. The block never resamples them after grant.
- The requester may drop i_req after o_gnt. If i_req is still set after ack, it is treated as a new request.
- o_mdr_data = 0 outside LOAD_X and LOAD_Y.
- o_mdr_op = latched op from START through RESP, 0 in IDLE.
- Reset values: state IDLE, every output 0, pointer 1, timeout counter 0.
- Asynchronous reset mid-operation returns to IDLE immediately and discards the pending response. The next o_mdr_start re-initialises the MDR.

## Timing
- Request seen in IDLE at cycle 0 -> o_gnt and o_mdr_start at cycle 1.
- With an MDR that asserts load_x and load_y immediately: LOAD_X at cycle 3, LOAD_Y at cycle 5.
- o_valid rises the cycle after i_mdr_ready or i_mdr_error is seen in BUSY.
- Ack seen at cycle k -> IDLE at k+1. The earliest next grant is k+2.
- Minimum turnaround between two grants is 8 cycles plus MDR compute time.
- Every outbound pulse (gnt, start, load) is exactly one cycle wide. All outputs are registered.

## Configuration
MDR_ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT_X, WAIT_Y and BUSY, and increments every cycle spent in those states.
  - When the count equals TIMEOUT while still waiting: go to RESP with o_err=1, o_timeout=1, result and remainder 0.
  - A same-cycle MDR event takes precedence over the timeout.
- Undefined: no counter; the arbiter waits indefinitely and o_timeout is constant 0.

## Test plan
- Reset: all outputs 0, o_busy=0. Req0 only, op=00, x=7, y=6, MDR returns 42/0 -> o_valid=01, o_result=42, o_err=0; ack clears valid the next cycle.
- Simultaneous requests right after reset -> requester 0 granted first. After its ack, requester 1 is granted with no new tie-break. A third tie grants 0 again.
- Req1 op=01, x=17, y=5, MDR returns 3/2 -> o_reminder=2. o_mdr_data shows 17 only in LOAD_X and 5 only in LOAD_Y. o_mdr_op=01 throughout.
- Req0 op=01, y=0, MDR raises i_mdr_error in the same cycle as ready -> o_err=1, o_result=0, o_valid=01.
- With MDR_ARB_TIMEOUT_EN and TIMEOUT=10, MDR never raises load_y -> o_valid, o_err=1, o_timeout=1 after exactly 10 cycles in WAIT_Y. Without the macro, o_busy stays 1 for 1000 cycles.
- Assert rst during BUSY -> all outputs 0 asynchronously. A subsequent request completes normally with a fresh o_mdr_start.
